system_memory_v5: RTL and testbench
===================================

# system_memory_v5

Parametrised grid state memory holding one `DATA_SIZE`-bit generation for the Conway core, with a `LANES`-bit-wide serial load and unload path to the external interface. An internal controller counts beats, so every load and every readout is always exactly one full frame. A readout rotates the frame back to its original alignment, so memory contents are never disturbed by unloading. The block sits between the grid calculator (`GRID_IN`/`SYSTEM_MEM_OUT`) and the external serial interface, and replaces the free-running shift memory.

## Interface
- `DATA_SIZE`, 64, total stored bits (grid cells); must be a multiple of `LANES`.
- `LANES`, 1, serial lane width in bits; 1 ≤ `LANES` ≤ `DATA_SIZE`.
- Derived: `BEATS` = `DATA_SIZE`/`LANES`. Beat counter width is $clog2(`BEATS`+1).

Ports:
- `CLK`  in  1  system clock; single clock domain.
- `RESET`  in  1  reset, synchronous and active-high.
- `GRID_IN`  in  `DATA_SIZE`  next generation from the grid calculator.
- `RUN_MODE`  in  1  level; capture `GRID_IN` (sampled only in IDLE).
- `LOAD_START`  in  1  pulse; begin a full-frame serial load.
- `OUTPUT_START`  in  1  pulse; begin a full-frame serial readout.
- `SERIAL_IN`  in  `LANES`  load data beat.
- `SERIAL_IN_VALID`  in  1  `SERIAL_IN` holds a beat.
- `SERIAL_IN_READY`  out  1  high in LOAD.
- `SERIAL_OUT`  out  `LANES`  readout beat = `SYSTEM_MEM_OUT[DATA_SIZE-1 -: LANES]`.
- `SERIAL_OUT_VALID`  out  1  high in OUTPUT.
- `SERIAL_OUT_READY`  in  1  consumer accepts the beat.
- `SYSTEM_MEM_OUT`  out  `DATA_SIZE`  stored frame.
- `BUSY`  out  1  state ≠ IDLE.
- `LOAD_DONE`, `OUTPUT_DONE`  out  1  registered one-cycle completion pulses.

## Operation
- States: IDLE, LOAD, OUTPUT. Register: `mem` (drives `SYSTEM_MEM_OUT`), beat counter `cnt`.
- IDLE priority, highest first:
  - `RUN_MODE`: `mem` <= `GRID_IN`; stay in IDLE.
  - else `LOAD_START`: go to LOAD, `cnt` <= 0.
  - else `OUTPUT_START`: go to OUTPUT, `cnt` <= 0.
- LOAD: an accepted beat is `SERIAL_IN_VALID`&&`SERIAL_IN_READY`.
  - On each accepted beat: `mem` <= {`mem`[`DATA_SIZE`-`LANES`-1:0], `SERIAL_IN`}, and `cnt` increments. The first beat received ends up in the MSBs.
  - On the beat with `cnt`==`BEATS`-1: go to IDLE and set `LOAD_DONE` <= 1.
- OUTPUT: a transfer is `SERIAL_OUT_VALID`&&`SERIAL_OUT_READY`.
  - On each transfer: `mem` <= {`mem`[`DATA_SIZE`-`LANES`-1:0], `mem`[`DATA_SIZE`-1 -: `LANES`]} (rotate by `LANES`), and `cnt` increments.
  - On the transfer with `cnt`==`BEATS`-1: go to IDLE and set `OUTPUT_DONE` <= 1.
  - After `BEATS` transfers, `mem` equals its pre-readout value.
- While `READY`/`VALID` is low, `mem` and `cnt` hold and `SERIAL_OUT` stays stable.
- While BUSY, `RUN_MODE`, `LOAD_START` and `OUTPUT_START` are ignored. They are not queued.
- `SERIAL_IN` is ignored outside LOAD. `SERIAL_OUT_READY` is ignored outside OUTPUT.
- When `LANES`==`DATA_SIZE` (`BEATS`=1): a single beat completes the operation. A load replaces `mem`; a readout leaves `mem` unchanged.

## Timing
- Reset (sampled at a `CLK` edge): state=IDLE, `mem`=0, `cnt`=0, `LOAD_DONE`=`OUTPUT_DONE`=0.
  - Consequently `SYSTEM_MEM_OUT`=0, `SERIAL_OUT`=0, `BUSY`=0, and both `VALID`/`READY` outputs are 0.
  - Reset mid-LOAD or mid-OUTPUT aborts immediately with the same values. A partial frame is discarded; no DONE pulse.
- `RUN_MODE` high at edge T: `SYSTEM_MEM_OUT`=`GRID_IN` after T (1-cycle latency).
- `LOAD_START` or `OUTPUT_START` at edge T: `BUSY`, and `SERIAL_IN_READY` or `SERIAL_OUT_VALID`, are high after T. The first beat can transfer at edge T+1.
- With no stalls, the final beat transfers at edge T+`BEATS`.
  - After that edge: `BUSY`=0 and the DONE pulse is high for exactly one cycle.
  - A new command is accepted at edge T+`BEATS`+1.
- `SERIAL_OUT_VALID`, `SERIAL_IN_READY` and `BUSY` are pure decodes of the state register. There is no combinational path from any input to any output.

## Test plan
- Reset: drive garbage on all inputs and assert `RESET` for 1 cycle, including once mid-OUTPUT at beat 5 -> `SYSTEM_MEM_OUT`=0, `BUSY`=0, no DONE pulse, next `OUTPUT_START` emits 16 beats of 0.
- Run capture (64/4): `RUN_MODE`=1 with `GRID_IN`=64'hDEADBEEF_01234567, and simultaneously `LOAD_START`=1 -> `SYSTEM_MEM_OUT` equals the value one cycle later; `BUSY` stays 0.
- Load (64/4): `LOAD_START`, then 16 beats 4'hF,4'hE,…,4'h0 with `SERIAL_IN_VALID` low every third cycle -> `SYSTEM_MEM_OUT`=64'hFEDCBA9876543210; `LOAD_DONE` pulses once, in the cycle after beat 16.
- Readout with back-pressure: `mem`=64'hFEDCBA9876543210, `OUTPUT_START`, `SERIAL_OUT_READY` toggling randomly -> beats F,E,…,0 in order, each held stable while stalled; `mem` restored afterward; a second readout repeats the identical sequence.
- Command blocking: `OUTPUT_START` and `RUN_MODE` asserted during a load -> both ignored; the load completes correctly and `mem` is unaffected by `GRID_IN`.
- Degenerate widths: `LANES`=1 (64 beats) and `LANES`=64 (1 beat) load/readout round-trip of 64'hA5A5_5A5A_0F0F_F0F0 -> readout bits match load bits, and DONE timing follows T+`BEATS`.

Source files
------------

// File: rtl/system_memory_v5.sv
// Grid state memory for the Conway core with a beat-counted, full-frame serial load/unload path.
// A readout rotates the frame, so after BEATS transfers the stored generation is back in place.
module system_memory_v5 #(
  parameter int DATA_SIZE = 64,
  parameter int LANES     = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATA_SIZE-1:0] GRID_IN,
  input  logic                 RUN_MODE,
  input  logic                 LOAD_START,
  input  logic                 OUTPUT_START,
  input  logic [LANES-1:0]     SERIAL_IN,
  input  logic                 SERIAL_IN_VALID,
  output logic                 SERIAL_IN_READY,
  output logic [LANES-1:0]     SERIAL_OUT,
  output logic                 SERIAL_OUT_VALID,
  input  logic                 SERIAL_OUT_READY,
  output logic [DATA_SIZE-1:0] SYSTEM_MEM_OUT,
  output logic                 BUSY,
  output logic                 LOAD_DONE,
  output logic                 OUTPUT_DONE
);

  localparam int BEATS = DATA_SIZE / LANES;
  localparam int CW    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_OUTPUT
  } state_t;

  state_t               state_reg, state_next;
  logic [DATA_SIZE-1:0] mem_reg, mem_next;
  logic [DATA_SIZE-1:0] load_shift, rot_shift;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 load_done_reg, load_done_next;
  logic                 output_done_reg, output_done_next;
  logic                 last_beat;

  // With a single beat per frame there is nothing left over to shift; the
  // beat replaces the whole frame and a rotation is the identity.
  generate
    if (LANES == DATA_SIZE) begin : g_full
      assign load_shift = SERIAL_IN;
      assign rot_shift  = mem_reg;
    end else begin : g_part
      assign load_shift = {mem_reg[DATA_SIZE-LANES-1:0], SERIAL_IN};
      assign rot_shift  = {mem_reg[DATA_SIZE-LANES-1:0], mem_reg[DATA_SIZE-1 -: LANES]};
    end
  endgenerate

  assign last_beat = (cnt_reg == CW'(BEATS - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg       <= ST_IDLE;
      mem_reg         <= '0;
      cnt_reg         <= '0;
      load_done_reg   <= 1'b0;
      output_done_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mem_reg         <= mem_next;
      cnt_reg         <= cnt_next;
      load_done_reg   <= load_done_next;
      output_done_reg <= output_done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    mem_next         = mem_reg;
    cnt_next         = cnt_reg;
    load_done_next   = 1'b0;
    output_done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Capture wins over both serial commands; nothing is queued.
        if (RUN_MODE) begin
          mem_next = GRID_IN;
        end else if (LOAD_START) begin
          state_next = ST_LOAD;
          cnt_next   = '0;
        end else if (OUTPUT_START) begin
          state_next = ST_OUTPUT;
          cnt_next   = '0;
        end
      end
      ST_LOAD: begin
        if (SERIAL_IN_VALID) begin
          mem_next = load_shift;
          cnt_next = cnt_reg + CW'(1);
          if (last_beat) begin
            state_next     = ST_IDLE;
            load_done_next = 1'b1;
          end
        end
      end
      ST_OUTPUT: begin
        if (SERIAL_OUT_READY) begin
          mem_next = rot_shift;
          cnt_next = cnt_reg + CW'(1);
          if (last_beat) begin
            state_next       = ST_IDLE;
            output_done_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign SERIAL_IN_READY  = (state_reg == ST_LOAD);
  assign SERIAL_OUT_VALID = (state_reg == ST_OUTPUT);
  assign BUSY             = (state_reg != ST_IDLE);
  assign SERIAL_OUT       = mem_reg[DATA_SIZE-1 -: LANES];
  assign SYSTEM_MEM_OUT   = mem_reg;
  assign LOAD_DONE        = load_done_reg;
  assign OUTPUT_DONE      = output_done_reg;

endmodule

// File: tb/tb_system_memory_v5.sv
// Scoreboard bench: expected readout beats are queued at stimulus time and popped by per-instance monitors.
module tb_system_memory_v5;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  // 64/4 instance
  logic [63:0] grid_in;
  logic        run_mode, load_start, output_start;
  logic [3:0]  sin, sout;
  logic        sin_valid, sin_ready, sout_valid, sout_ready;
  logic [63:0] mem_out;
  logic        busy, load_done, output_done;

  // 64/1 instance
  logic        l1_ls, l1_os, l1_sin, l1_sv, l1_sir, l1_sout, l1_svo, l1_sr;
  logic [63:0] l1_mem;
  logic        l1_busy, l1_ld, l1_od;

  // 64/64 instance
  logic        w_ls, w_os, w_sv, w_sir, w_svo, w_sr;
  logic [63:0] w_sin, w_sout, w_mem;
  logic        w_busy, w_ld, w_od;

  logic [63:0] zero64 = 64'h0;
  logic [3:0]  q4[$];
  logic        q1[$];
  logic [63:0] q64[$];
  int          ld_pulses = 0;
  int          od_pulses = 0;

  system_memory_v5 #(.DATA_SIZE(64), .LANES(4)) u_dut4 (
    .CLK(clk), .RESET(rst), .GRID_IN(grid_in), .RUN_MODE(run_mode),
    .LOAD_START(load_start), .OUTPUT_START(output_start),
    .SERIAL_IN(sin), .SERIAL_IN_VALID(sin_valid), .SERIAL_IN_READY(sin_ready),
    .SERIAL_OUT(sout), .SERIAL_OUT_VALID(sout_valid), .SERIAL_OUT_READY(sout_ready),
    .SYSTEM_MEM_OUT(mem_out), .BUSY(busy), .LOAD_DONE(load_done), .OUTPUT_DONE(output_done)
  );

  system_memory_v5 #(.DATA_SIZE(64), .LANES(1)) u_dut1 (
    .CLK(clk), .RESET(rst), .GRID_IN(zero64), .RUN_MODE(1'b0),
    .LOAD_START(l1_ls), .OUTPUT_START(l1_os),
    .SERIAL_IN(l1_sin), .SERIAL_IN_VALID(l1_sv), .SERIAL_IN_READY(l1_sir),
    .SERIAL_OUT(l1_sout), .SERIAL_OUT_VALID(l1_svo), .SERIAL_OUT_READY(l1_sr),
    .SYSTEM_MEM_OUT(l1_mem), .BUSY(l1_busy), .LOAD_DONE(l1_ld), .OUTPUT_DONE(l1_od)
  );

  system_memory_v5 #(.DATA_SIZE(64), .LANES(64)) u_dut64 (
    .CLK(clk), .RESET(rst), .GRID_IN(zero64), .RUN_MODE(1'b0),
    .LOAD_START(w_ls), .OUTPUT_START(w_os),
    .SERIAL_IN(w_sin), .SERIAL_IN_VALID(w_sv), .SERIAL_IN_READY(w_sir),
    .SERIAL_OUT(w_sout), .SERIAL_OUT_VALID(w_svo), .SERIAL_OUT_READY(w_sr),
    .SYSTEM_MEM_OUT(w_mem), .BUSY(w_busy), .LOAD_DONE(w_ld), .OUTPUT_DONE(w_od)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 64/4 instance: pops on each transfer, checks stall stability.
  logic [3:0] stall_val;
  bit         stall_pend = 0;
  logic [3:0] e4;
  always @(negedge clk) begin
    if (rst !== 1'b0 || sout_valid !== 1'b1) begin
      stall_pend = 0;
    end else begin
      if (stall_pend) check("stall_hold", 64'(sout), 64'(stall_val));
      if (sout_ready === 1'b1) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat4: got %h required none", sout);
        end else begin
          e4 = q4.pop_front();
          check("beat4", 64'(sout), 64'(e4));
        end
        stall_pend = 0;
      end else begin
        stall_pend = 1;
        stall_val  = sout;
      end
    end
    if (rst === 1'b0 && load_done === 1'b1) ld_pulses++;
    if (rst === 1'b0 && output_done === 1'b1) od_pulses++;
  end

  logic e1;
  always @(negedge clk) begin
    if (rst === 1'b0 && l1_svo === 1'b1 && l1_sr === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL beat1: got %h required none", l1_sout);
      end else begin
        e1 = q1.pop_front();
        check("beat1", 64'(l1_sout), 64'(e1));
      end
    end
  end

  logic [63:0] e64;
  always @(negedge clk) begin
    if (rst === 1'b0 && w_svo === 1'b1 && w_sr === 1'b1) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL beat64: got %h required none", w_sout);
      end else begin
        e64 = q64.pop_front();
        check("beat64", w_sout, e64);
      end
    end
  end

  task automatic load4(input logic [63:0] v, input bit block);
    int beat = 0;
    int cyc  = 0;
    int p0   = ld_pulses;
    load_start = 1; tick; load_start = 0;
    check("load_busy", 64'(busy), 64'(1));
    check("load_ready", 64'(sin_ready), 64'(1));
    while (beat < 16 && cyc < 100) begin
      if (cyc % 3 == 2) begin
        sin_valid = 0;
      end else begin
        sin_valid = 1;
        sin = v[63-4*beat -: 4];
        beat++;
      end
      if (block && beat == 8 && sin_valid) begin
        output_start = 1; run_mode = 1; grid_in = 64'hFFFF_0000_FFFF_0000;
      end
      tick;
      output_start = 0; run_mode = 0;
      cyc++;
    end
    sin_valid = 0;
    check("load_done_pulse", 64'(load_done), 64'(1));
    check("load_idle", 64'(busy), 64'(0));
    check("load_mem", mem_out, v);
    tick;
    check("load_done_end", 64'(load_done), 64'(0));
    check("load_pulse_count", 64'(ld_pulses), 64'(p0 + 1));
    check("load_no_queued_cmd", 64'(busy), 64'(0));
    $display("load4 %h complete in %0d cycles", v, cyc);
  endtask

  task automatic rd4(input logic [63:0] v, input bit rnd);
    int n = 0;
    for (int i = 0; i < 16; i++) q4.push_back(v[63-4*i -: 4]);
    output_start = 1; tick; output_start = 0;
    check("rd_valid", 64'(sout_valid), 64'(1));
    while (output_done !== 1'b1 && n < 400) begin
      sout_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      tick;
      n++;
    end
    sout_ready = 0;
    check("rd_timeout", 64'(n < 400), 64'(1));
    check("rd_idle", 64'(busy), 64'(0));
    check("rd_mem_restored", mem_out, v);
    check("rd_queue_empty", 64'(q4.size()), 64'(0));
    $display("rd4 %h complete in %0d cycles", v, n);
  endtask

  initial begin
    logic [63:0] v;
    int p;
    // Reset with garbage on every input
    rst = 1; grid_in = 64'h1234_5678_9ABC_DEF0; run_mode = 1; load_start = 1; output_start = 1;
    sin = 4'hA; sin_valid = 1; sout_ready = 1;
    l1_ls = 1; l1_os = 1; l1_sin = 1; l1_sv = 1; l1_sr = 1;
    w_ls = 1; w_os = 1; w_sin = 64'hFFFF_FFFF_FFFF_FFFF; w_sv = 1; w_sr = 1;
    tick;
    rst = 0; run_mode = 0; load_start = 0; output_start = 0; sin_valid = 0; sout_ready = 0;
    l1_ls = 0; l1_os = 0; l1_sv = 0; l1_sr = 0; w_ls = 0; w_os = 0; w_sv = 0; w_sr = 0;
    check("rst_mem", mem_out, 64'h0);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(sin_ready), 64'(0));
    check("rst_out_valid", 64'(sout_valid), 64'(0));
    check("rst_sout", 64'(sout), 64'(0));
    check("rst_dones", 64'({load_done, output_done}), 64'(0));
    check("rst_mem1", l1_mem, 64'h0);
    check("rst_mem64", w_mem, 64'h0);

    // Capture has priority over LOAD_START
    run_mode = 1; load_start = 1; grid_in = 64'hDEADBEEF_01234567;
    tick;
    run_mode = 0; load_start = 0;
    check("run_capture", mem_out, 64'hDEADBEEF_01234567);
    check("run_busy", 64'(busy), 64'(0));
    tick;
    check("run_no_queue", 64'(busy), 64'(0));

    load4(64'hFEDCBA9876543210, 0);
    rd4(64'hFEDCBA9876543210, 1);
    rd4(64'hFEDCBA9876543210, 1);

    // Commands and capture during a load are ignored
    load4(64'h0123456789ABCDEF, 1);
    rd4(64'h0123456789ABCDEF, 0);

    // Reset mid-readout after five beats
    for (int i = 0; i < 16; i++) q4.push_back(4'(64'h0123456789ABCDEF >> (60 - 4*i)));
    output_start = 1; tick; output_start = 0;
    sout_ready = 1;
    repeat (5) tick;
    rst = 1; run_mode = 1; load_start = 1; output_start = 1; sin_valid = 1; sin = 4'h5;
    grid_in = {$urandom, $urandom};
    tick;
    rst = 0; run_mode = 0; load_start = 0; output_start = 0; sin_valid = 0; sout_ready = 0;
    q4.delete();
    p = od_pulses;
    check("midrst_mem", mem_out, 64'h0);
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_valid", 64'(sout_valid), 64'(0));
    check("midrst_done", 64'({load_done, output_done}), 64'(0));
    tick;
    check("midrst_no_pulse", 64'(od_pulses), 64'(p));
    rd4(64'h0, 0);

    // LANES=1 round trip
    v = 64'hA5A5_5A5A_0F0F_F0F0;
    l1_ls = 1; tick; l1_ls = 0;
    for (int i = 0; i < 64; i++) begin
      l1_sin = v[63-i]; l1_sv = 1;
      tick;
      if (i == 62) check("l1_load_early", 64'(l1_ld), 64'(0));
    end
    l1_sv = 0;
    check("l1_load_done", 64'(l1_ld), 64'(1));
    check("l1_load_mem", l1_mem, v);
    tick;
    for (int i = 0; i < 64; i++) q1.push_back(v[63-i]);
    l1_os = 1; tick; l1_os = 0; l1_sr = 1;
    for (int i = 0; i < 64; i++) begin
      tick;
      if (i == 62) check("l1_rd_early", 64'(l1_od), 64'(0));
    end
    l1_sr = 0;
    check("l1_rd_done", 64'(l1_od), 64'(1));
    check("l1_rd_mem", l1_mem, v);
    check("l1_queue_empty", 64'(q1.size()), 64'(0));
    $display("lanes1 round trip %h", v);

    // LANES=64 round trip
    w_ls = 1; tick; w_ls = 0;
    check("w_ready", 64'(w_sir), 64'(1));
    w_sin = v; w_sv = 1; tick; w_sv = 0;
    check("w_load_done", 64'(w_ld), 64'(1));
    check("w_load_mem", w_mem, v);
    tick;
    q64.push_back(v);
    w_os = 1; tick; w_os = 0; w_sr = 1;
    tick; w_sr = 0;
    check("w_rd_done", 64'(w_od), 64'(1));
    check("w_rd_mem", w_mem, v);
    check("w_queue_empty", 64'(q64.size()), 64'(0));
    $display("lanes64 round trip %h", v);

    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
